p2s_sched: RTL and testbench

- Round-robin scheduler that shares one 16-bit parallel-to-serial serializer between N_REQ requesters.
- Each requester presents a word with a request/ack handshake. The block arbitrates, captures the winning word and emits the load and enable sequencing for the serializer datapath.
- It also emits bit-position and framing status for downstream logic.
- Sits between the word producers and the P2S shifter.

---
 rtl/p2s_sched.sv | 134 +++++++++++++
 tb/tb_p2s_sched.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/p2s_sched.sv
// p2s_sched: round-robin scheduler that shares one parallel-to-serial
// serializer between N_REQ requesters. It arbitrates among eligible
// requesters, captures the winning word and sequences load/shift/gap
// for the serializer, along with bit-position and framing status.
module p2s_sched #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 16,
   parameter int GAP   = 1,
   parameter int IDW   = 2
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [N_REQ-1:0]       i_req,
   input  logic [N_REQ*WIDTH-1:0] i_data,
   input  logic [N_REQ-1:0]       i_mask,
   output logic [N_REQ-1:0]       o_ack,
   output logic [IDW-1:0]         o_grant_id,
   output logic [WIDTH-1:0]       o_word,
   output logic                   o_load,
   output logic                   o_enable,
   output logic [3:0]             o_bit_cnt,
   output logic                   o_last,
   output logic                   o_busy
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_GAP
   } state_t;

   localparam logic [3:0]     CNT_LAST  = 4'(WIDTH - 1);
   localparam logic [3:0]     GAP_LAST  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
   localparam logic [IDW-1:0] RR_LAST   = IDW'(N_REQ - 1);

   state_t           state_q, state_d;
   logic [IDW-1:0]   rr_q, rr_d;
   logic [IDW-1:0]   grant_q, grant_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [3:0]       gap_cnt_q, gap_cnt_d;

   logic [N_REQ-1:0] eligible;
   logic             found;
   logic [IDW-1:0]   winner;

   // Pick the first eligible requester at or after the rr pointer, wrapping around
   always_comb begin
      eligible = i_req & ~i_mask;
      found    = 1'b0;
      winner   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && eligible[(int'(rr_q) + i) % N_REQ]) begin
            found  = 1'b1;
            winner = IDW'((int'(rr_q) + i) % N_REQ);
         end
      end
   end

   // Next-state logic: capture in IDLE, advance rr in LOAD, count shift and gap cycles
   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      grant_d   = grant_q;
      word_d    = word_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               grant_d = winner;
               word_d  = i_data[int'(winner)*WIDTH +: WIDTH];
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            rr_d      = (grant_q == RR_LAST) ? '0 : grant_q + 1'b1;
            bit_cnt_d = '0;
            state_d   = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (bit_cnt_q == CNT_LAST) begin
               bit_cnt_d = '0;
               if (GAP > 0) begin
                  gap_cnt_d = '0;
                  state_d   = ST_GAP;
               end else begin
                  state_d   = ST_IDLE;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any word in flight
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         rr_q      <= '0;
         grant_q   <= '0;
         word_q    <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         grant_q   <= grant_d;
         word_q    <= word_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
      end
   end

   assign o_ack      = (state_q == ST_LOAD) ? (N_REQ'(1) << grant_q) : '0;
   assign o_grant_id = grant_q;
   assign o_word     = word_q;
   assign o_load     = (state_q == ST_LOAD);
   assign o_enable   = (state_q == ST_SHIFT);
   assign o_bit_cnt  = bit_cnt_q;
   assign o_last     = (state_q == ST_SHIFT) && (bit_cnt_q == CNT_LAST);
   assign o_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_p2s_sched.sv
// tb_p2s_sched: directed bench for p2s_sched with hand-computed expectations.
// A second instance built with GAP=0 checks the back-to-back word cadence.
module tb_p2s_sched;

   logic        clk;
   logic        rst, rst2;
   logic [3:0]  req, mask, req2, mask2;
   logic [63:0] data;

   logic [3:0]  ack, ack2;
   logic [1:0]  gid, gid2;
   logic [15:0] word, word2;
   logic        load, load2, en, en2, last, last2, busy, busy2;
   logic [3:0]  cnt, cnt2;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   p2s_sched #(.N_REQ(4), .WIDTH(16), .GAP(1), .IDW(2)) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_data(data), .i_mask(mask),
      .o_ack(ack), .o_grant_id(gid), .o_word(word), .o_load(load),
      .o_enable(en), .o_bit_cnt(cnt), .o_last(last), .o_busy(busy)
   );

   p2s_sched #(.N_REQ(4), .WIDTH(16), .GAP(0), .IDW(2)) dut_gap0 (
      .i_clk(clk), .i_rst(rst2), .i_req(req2), .i_data(data), .i_mask(mask2),
      .o_ack(ack2), .o_grant_id(gid2), .o_word(word2), .o_load(load2),
      .o_enable(en2), .o_bit_cnt(cnt2), .o_last(last2), .o_busy(busy2)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case a bounded wait is somehow bypassed
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic applyStimulus(input logic [3:0] r, input logic [3:0] m);
      req  = r;
      mask = m;
   endtask

   task automatic waitLoad(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick;
         if (load) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      bit ok;
      int n, cntErr, lastErr, bad, prev, loads, busyCnt;

      rst  = 1'b1;
      rst2 = 1'b1;
      req2 = 4'b0000;
      mask2 = 4'b0000;
      data = 64'h0;
      applyStimulus(4'b0000, 4'b0000);
      tick;

      // Single requester: reset outputs, latency, 16 shift cycles, last, gap
      $display("[TB] single requester");
      applyStimulus(4'b0001, 4'b0000);
      data[15:0] = 16'hCCCC;
      tick;
      checkOutput("reset_outputs", {ack, gid, word, load, en, cnt, last, busy}, 32'h0);
      rst = 1'b0;
      checkOutput("idle_no_load", load, 1'b0);
      tick;
      checkOutput("t1_load", load, 1'b1);
      checkOutput("t1_ack", ack, 4'b0001);
      checkOutput("t1_gid", gid, 2'd0);
      checkOutput("t1_word", word, 16'hCCCC);
      req = 4'b0000;
      tick;
      n = 0; cntErr = 0; lastErr = 0;
      while (en && n < 40) begin
         if (cnt !== 4'(n)) cntErr++;
         if (last !== (n == 15)) lastErr++;
         n++;
         tick;
      end
      checkOutput("t1_enable_len", n, 16);
      checkOutput("t1_bitcnt_seq", cntErr, 0);
      checkOutput("t1_last_pos", lastErr, 0);
      checkOutput("t1_gap_busy", {busy, en}, 2'b10);
      tick;
      checkOutput("t1_idle_busy", busy, 1'b0);

      // Round-robin: all requesting from reset gives 0,1,2,3,0 every 19 cycles
      $display("[TB] round robin");
      rst = 1'b1;
      applyStimulus(4'b1111, 4'b0000);
      data = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
      tick;
      rst = 1'b0;
      prev = 0;
      for (int k = 0; k < 5; k++) begin
         waitLoad(30, ok);
         if (!ok) begin
            checkOutput("rr_timeout", 0, 1);
            break;
         end
         checkOutput("rr_gid", gid, k % 4);
         checkOutput("rr_word", word, 16'hA000 + (k % 4));
         if (k > 0) checkOutput("rr_spacing", cyc - prev, 19);
         prev = cyc;
      end

      // Masking: requester 1 excluded, only 2 is served repeatedly
      $display("[TB] masking");
      rst = 1'b1;
      applyStimulus(4'b0110, 4'b0010);
      tick;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         waitLoad(30, ok);
         if (!ok) begin
            checkOutput("mask_timeout", 0, 1);
            break;
         end
         checkOutput("mask_gid", gid, 2'd2);
         checkOutput("mask_ack", ack, 4'b0100);
      end
      rst = 1'b1;
      applyStimulus(4'b0110, 4'b0110);
      tick;
      rst = 1'b0;
      loads = 0; busyCnt = 0;
      for (int i = 0; i < 40; i++) begin
         tick;
         loads += int'(load);
         busyCnt += int'(busy);
      end
      checkOutput("allmask_loads", loads, 0);
      checkOutput("allmask_busy", busyCnt, 0);

      // Data stability: changing the source after capture leaves o_word alone
      $display("[TB] data stability");
      rst = 1'b1;
      applyStimulus(4'b0010, 4'b0000);
      data = 64'h0;
      data[31:16] = 16'h1234;
      tick;
      rst = 1'b0;
      waitLoad(30, ok);
      if (!ok) checkOutput("stab_timeout", 0, 1);
      checkOutput("stab_ack", ack, 4'b0010);
      checkOutput("stab_word_load", word, 16'h1234);
      req = 4'b0000;
      data[31:16] = 16'hFFFF;
      tick;
      n = 0; bad = 0;
      while (en && n < 40) begin
         if (word !== 16'h1234) bad++;
         n++;
         tick;
      end
      checkOutput("stab_shift_len", n, 16);
      checkOutput("stab_word_held", bad, 0);

      // Reset mid-shift at bit 7, then requester 3 is re-served from scratch
      $display("[TB] reset mid-shift");
      rst = 1'b1;
      applyStimulus(4'b1000, 4'b0000);
      tick;
      rst = 1'b0;
      waitLoad(30, ok);
      if (!ok) checkOutput("rmid_timeout", 0, 1);
      checkOutput("rmid_gid", gid, 2'd3);
      for (int i = 0; i < 20; i++) begin
         tick;
         if (en && cnt == 4'd7) break;
      end
      checkOutput("rmid_at_bit7", {en, cnt}, {1'b1, 4'd7});
      rst = 1'b1;
      tick;
      checkOutput("rmid_all_zero", {ack, gid, word, load, en, cnt, last, busy}, 32'h0);
      rst = 1'b0;
      checkOutput("rmid_idle_no_load", load, 1'b0);
      tick;
      checkOutput("rmid_reload", load, 1'b1);
      checkOutput("rmid_ack", ack, 4'b1000);

      // GAP=0 build: back-to-back words 18 cycles apart, IDLE right after last shift
      $display("[TB] gap zero build");
      req2 = 4'b1111;
      tick;
      rst2 = 1'b0;
      prev = 0;
      for (int k = 0; k < 3; k++) begin
         ok = 1'b0;
         for (int i = 0; i < 30; i++) begin
            tick;
            if (load2) begin
               ok = 1'b1;
               break;
            end
         end
         if (!ok) begin
            checkOutput("g0_timeout", 0, 1);
            break;
         end
         checkOutput("g0_gid", gid2, k);
         if (k > 0) checkOutput("g0_spacing", cyc - prev, 18);
         prev = cyc;
      end
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick;
         if (last2) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) checkOutput("g0_last_timeout", 0, 1);
      tick;
      checkOutput("g0_no_gap", {busy2, en2, load2}, 3'b000);
      tick;
      checkOutput("g0_next_load", load2, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
